game_target_mover: RTL

GAME_TARGET_MOVER -- requirements
Module: game_target_mover

---
 rtl/game_target_mover.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/game_target_mover.sv
// Moves N_TARGETS sprites around a 640x480 playfield. Targets are launched in a
// staggered row, bounce off the screen edges and reverse direction on collisions.
`ifndef N_TARGETS
`define N_TARGETS 4
`endif

module game_target_mover #(
    parameter int N_TARGETS = `N_TARGETS,
    parameter int w_x       = $clog2(640),
    parameter int w_y       = $clog2(480),
    parameter int SPRITE_W  = 16,
    parameter int SPRITE_H  = 16,
    parameter int SPEED     = 2,
    parameter int X_SPACING = 64,
    parameter int Y_START   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          launch,
    input  logic                          stop,
    input  logic                          frame_tick,
    input  logic                          random,
    input  logic [N_TARGETS-1:0]          collide_x,
    input  logic [N_TARGETS-1:0]          collide_y,
    output logic [N_TARGETS-1:0][w_x-1:0] sprite_left,
    output logic [N_TARGETS-1:0][w_x-1:0] sprite_right,
    output logic [N_TARGETS-1:0][w_y-1:0] sprite_top,
    output logic [N_TARGETS-1:0][w_y-1:0] sprite_bottom,
    output logic                          running
);

    localparam int X_MAX = 640 - SPRITE_W;
    localparam int Y_MAX = 480 - SPRITE_H;
    localparam int IW    = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;

    typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

    state_t                        state;
    logic [IW-1:0]                 index;
    logic [N_TARGETS-1:0][w_x-1:0] x;
    logic [N_TARGETS-1:0][w_y-1:0] y;
    logic [N_TARGETS-1:0]          dir_x;
    logic [N_TARGETS-1:0]          dir_y;
    logic [N_TARGETS-1:0]          pend_x;
    logic [N_TARGETS-1:0]          pend_y;
    logic [N_TARGETS-1:0]          eff_dx;
    logic [N_TARGETS-1:0]          eff_dy;

    // Edge arithmetic is done in int so the limit tests can never wrap.
    function automatic int step_pos(input int pos, input logic dec, input int lim);
        if (dec)
            return (pos >= SPEED) ? pos - SPEED : 0;
        else
            return (pos + SPEED <= lim) ? pos + SPEED : lim;
    endfunction

    function automatic logic step_dir(input int pos, input logic dec, input int lim);
        if (dec)
            return (pos >= SPEED);
        else
            return (pos + SPEED > lim);
    endfunction

    // A collision seen in the tick cycle itself still counts toward that tick.
    always_comb begin
        eff_dx = dir_x ^ (pend_x | collide_x);
        eff_dy = dir_y ^ (pend_y | collide_y);
    end

    always_comb begin
        for (int k = 0; k < N_TARGETS; k++) begin
            sprite_left[k]   = x[k];
            sprite_right[k]  = x[k] + w_x'(SPRITE_W);
            sprite_top[k]    = y[k];
            sprite_bottom[k] = y[k] + w_y'(SPRITE_H);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            index   <= '0;
            running <= 1'b0;
            x       <= '0;
            y       <= '0;
            dir_x   <= '0;
            dir_y   <= '0;
            pend_x  <= '0;
            pend_y  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        state <= INIT;
                        index <= '0;
                    end
                end
                INIT: begin
                    if (stop) begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end else begin
                        x[index]      <= w_x'(int'(index) * X_SPACING);
                        y[index]      <= w_y'(Y_START);
                        dir_x[index]  <= random;
                        dir_y[index]  <= 1'b0;
                        pend_x[index] <= 1'b0;
                        pend_y[index] <= 1'b0;
                        index         <= index + 1'b1;
                        if (index == IW'(N_TARGETS - 1)) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end else if (frame_tick) begin
                        for (int k = 0; k < N_TARGETS; k++) begin
                            x[k]     <= w_x'(step_pos(int'(x[k]), eff_dx[k], X_MAX));
                            dir_x[k] <= step_dir(int'(x[k]), eff_dx[k], X_MAX);
                            y[k]     <= w_y'(step_pos(int'(y[k]), eff_dy[k], Y_MAX));
                            dir_y[k] <= step_dir(int'(y[k]), eff_dy[k], Y_MAX);
                        end
                        pend_x <= '0;
                        pend_y <= '0;
                    end else begin
                        pend_x <= pend_x | collide_x;
                        pend_y <= pend_y | collide_y;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule
